div_int_seq: RTL
================

Name: div_int_seq

Overview:
- Iterative signed integer divider, the inverse operation of the team's combinational signed multiplier.
- Uses the same sign-magnitude scheme: take absolute values, divide unsigned, re-apply signs.
- Computes quotient and remainder over bit_width cycles using one restoring step per cycle.
- Sits in the arith util library, behind a valid/ready handshake, for MX scale/normalisation paths.

Parameters:
- bit_width, 8, width of the dividend, divisor, quotient and remainder (signed two's complement).

Ports:
- i_clk  input  1  clock; rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  operands valid.
- o_ready  output  1  divider idle and able to accept; equals (state == IDLE).
- i_dvd  input  bit_width  signed dividend.
- i_dvs  input  bit_width  signed divisor.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_quo  output  bit_width  signed quotient.
- o_rem  output  bit_width  signed remainder.
- o_div_zero  output  1  divisor was zero.
- o_ovf  output  1  quotient saturated.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, iteration counter=0, all datapath registers 0.
  - o_valid=0, o_quo=0, o_rem=0, o_div_zero=0, o_ovf=0, o_ready=1.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on the edge where i_valid && o_ready.
  - On accept, register: sign_q = dvd<0 XOR dvs<0; sign_r = dvd<0; |dvd| and |dvs| as unsigned bit_width values (|-2^(n-1)| = 2^(n-1) fits unsigned); zero flag; overflow flag.
  - Overflow flag: dvd = -2^(bit_width-1) and dvs = -1.
  - Counter is set to bit_width-1, then go to CALC.
- CALC:
  - Each cycle performs one restoring step: partial remainder = {prem, next dividend MSB}; if that value >= |dvs|, subtract and shift in quotient bit 1, else shift in 0.
  - Counter decrements each cycle.
  - On the edge where counter==0, go to DONE and load the output registers.
- Result rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend (C semantics). Output = sign ? -magnitude : magnitude.
  - Divisor zero: o_quo=0, o_rem=dividend, o_div_zero=1. CALC still runs so latency stays uniform.
  - Overflow: o_quo = 2^(bit_width-1)-1, o_rem=0, o_ovf=1.
  - Otherwise both flags are 0.
- Latency: accept on edge E gives o_valid=1 after edge E+bit_width. This is fixed and independent of the operand values.
- DONE:
  - o_valid=1; outputs hold stable while i_ready=0, for unbounded backpressure.
  - On the edge with i_ready=1, go to IDLE and set o_valid=0. o_ready rises in the following cycle; there is no same-cycle result handoff and new accept.
- Operand inputs are ignored outside the accept edge. i_valid while busy is not an error; the producer holds it until o_ready.
- Reset asserted mid-CALC or in DONE aborts the operation immediately, with the same values as reset; no partial result is emitted.

Decomposition:
- arith_pkg (shared) holds:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, DONE}.
  - Localparam helper for counter width $clog2(bit_width).
- div_int_step is one natural combinational sub-module:
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once; the sequential loop lives in div_int_seq.

Test Plan (bit_width=8):
- 100 / 7 accepted at edge E: o_valid after E+8, o_quo=14, o_rem=2, both flags 0.
- Sign combinations:
  - -100/7 gives -14 r -2.
  - 100/-7 gives -14 r 2.
  - -100/-7 gives 14 r -2.
  - -128/1 gives -128 r 0.
- Overflow: -128 / -1 gives o_quo=127, o_rem=0, o_ovf=1, o_div_zero=0. 37 / 0 gives o_quo=0, o_rem=37, o_div_zero=1, o_ovf=0.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid; outputs stay stable and o_ready=0. Then pulse i_ready; o_valid drops and o_ready=1 the next cycle. Operands applied during CALC and DONE are ignored.
- Reset mid-operation: start 100/7, assert i_rst_n=0 mid-cycle after 3 CALC iterations. o_valid=0 and o_ready=1 immediately (asynchronously). After release, 9 / 3 returns o_quo=3, o_rem=0 at E+8.
- Random sweep: 10k random operand pairs with random i_valid/i_ready gaps, checked against a reference model of truncating division plus the zero and overflow rules. Latency must always equal 8.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-utility package.
// Holds the divider FSM state type and a helper that sizes iteration counters.
package arith_pkg;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Counter width for a loop that runs `w` iterations (counts w-1 down to 0).
  // Clamped to 1 so a degenerate width still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_int_step.sv
// One restoring-division step (combinational).
// Ports:
//   prem_i     partial remainder before this step (unsigned, < dvs_i when dvs_i != 0)
//   dvd_bit_i  next dividend bit, shifted into the partial remainder LSB
//   dvs_i      divisor magnitude (unsigned)
//   prem_o     partial remainder after this step
//   quo_bit_o  quotient bit produced by this step
module div_int_step #(
  parameter int unsigned bit_width = 8
) (
  input  logic [bit_width-1:0] prem_i,
  input  logic                 dvd_bit_i,
  input  logic [bit_width-1:0] dvs_i,
  output logic [bit_width-1:0] prem_o,
  output logic                 quo_bit_o
);

  // One extra bit so the compare is exact even if the shift carries out.
  logic [bit_width:0] trial;

  always_comb begin
    trial     = {prem_i, dvd_bit_i};
    quo_bit_o = (trial >= {1'b0, dvs_i});
    // When the subtraction is taken the true result is below dvs_i, so the
    // low bits alone carry the exact difference.
    prem_o    = quo_bit_o ? (trial[bit_width-1:0] - dvs_i) : trial[bit_width-1:0];
  end

endmodule

// File: rtl/div_int_seq.sv
// Iterative signed integer divider (sign-magnitude, one restoring step per cycle).
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Fixed latency: accept on edge E -> o_valid after edge E+bit_width.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_valid / o_ready     operand handshake; o_ready is high only in IDLE
//   i_dvd, i_dvs          signed dividend / divisor
//   o_valid / i_ready     result handshake; outputs hold while i_ready is low
//   o_quo, o_rem          signed quotient / remainder
//   o_div_zero            divisor was zero (o_quo=0, o_rem=dividend)
//   o_ovf                 -2^(n-1) / -1 saturated (o_quo=2^(n-1)-1, o_rem=0)
module div_int_seq
  import arith_pkg::*;
#(
  parameter int unsigned bit_width = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [bit_width-1:0] i_dvd,
  input  logic [bit_width-1:0] i_dvs,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [bit_width-1:0] o_quo,
  output logic [bit_width-1:0] o_rem,
  output logic                 o_div_zero,
  output logic                 o_ovf
);

  localparam int unsigned CntW = cnt_width(bit_width);
  localparam logic [bit_width-1:0] MinVal = {1'b1, {(bit_width-1){1'b0}}};
  localparam logic [bit_width-1:0] MaxVal = {1'b0, {(bit_width-1){1'b1}}};

  div_state_t           state_q;
  logic [CntW-1:0]      cnt_q;
  logic [bit_width-1:0] qd_q;     // dividend bits shift out of the MSB, quotient bits in at LSB
  logic [bit_width-1:0] dvs_q;    // divisor magnitude
  logic [bit_width-1:0] prem_q;   // partial remainder
  logic [bit_width-1:0] dvd_q;    // raw dividend, returned as remainder on divide-by-zero
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 zero_q;
  logic                 ovf_flag_q;

  logic                 valid_q;
  logic [bit_width-1:0] quo_q;
  logic [bit_width-1:0] rem_q;
  logic                 div_zero_q;
  logic                 ovf_q;

  // Operand magnitudes; |-2^(n-1)| wraps to 2^(n-1), which is correct as unsigned.
  logic [bit_width-1:0] dvd_abs;
  logic [bit_width-1:0] dvs_abs;

  logic [bit_width-1:0] step_prem;
  logic                 step_qbit;
  logic [bit_width-1:0] quo_mag;
  logic [bit_width-1:0] res_quo;
  logic [bit_width-1:0] res_rem;

  div_int_step #(
    .bit_width(bit_width)
  ) u_step (
    .prem_i   (prem_q),
    .dvd_bit_i(qd_q[bit_width-1]),
    .dvs_i    (dvs_q),
    .prem_o   (step_prem),
    .quo_bit_o(step_qbit)
  );

  always_comb begin
    dvd_abs = i_dvd[bit_width-1] ? -i_dvd : i_dvd;
    dvs_abs = i_dvs[bit_width-1] ? -i_dvs : i_dvs;
  end

  // Final result, formed from the last step's outputs so it can be loaded on
  // the same edge that completes the last iteration.
  always_comb begin
    quo_mag = {qd_q[bit_width-2:0], step_qbit};
    if (zero_q) begin
      res_quo = '0;
      res_rem = dvd_q;
    end else if (ovf_flag_q) begin
      res_quo = MaxVal;
      res_rem = '0;
    end else begin
      res_quo = neg_quo_q ? -quo_mag : quo_mag;
      res_rem = neg_rem_q ? -step_prem : step_prem;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      qd_q       <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            qd_q       <= dvd_abs;
            dvs_q      <= dvs_abs;
            prem_q     <= '0;
            dvd_q      <= i_dvd;
            neg_quo_q  <= i_dvd[bit_width-1] ^ i_dvs[bit_width-1];
            neg_rem_q  <= i_dvd[bit_width-1];
            zero_q     <= (i_dvs == '0);
            ovf_flag_q <= (i_dvd == MinVal) && (i_dvs == '1);
            cnt_q      <= CntW'(bit_width - 1);
            state_q    <= CALC;
          end
        end
        CALC: begin
          prem_q <= step_prem;
          qd_q   <= {qd_q[bit_width-2:0], step_qbit};
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            quo_q      <= res_quo;
            rem_q      <= res_rem;
            div_zero_q <= zero_q;
            ovf_q      <= ovf_flag_q;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = valid_q;
  assign o_quo      = quo_q;
  assign o_rem      = rem_q;
  assign o_div_zero = div_zero_q;
  assign o_ovf      = ovf_q;

endmodule
